// File: rtl/tpu_act_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tpu_act_feeder
// Description : Buffers up to DEPTH 3-lane activation vectors, then streams
//               them into the left edge of a 3x3 systolic array with a
//               one-cycle skew per lane, followed by TAIL zero cycles.
// Revision    : 1.0  initial release
// ============================================================================
module tpu_act_feeder #(
  parameter int DEPTH = 8,
  parameter int TAIL  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] vec_i,
  input  logic        vec_valid,
  output logic        vec_ready,
  input  logic        start,
  output logic [23:0] act_o,
  output logic        en_o,
  output logic        busy,
  output logic        done,
  output logic [3:0]  count_o
);

  // Run-cycle counter must reach DEPTH+TAIL-1.
  localparam int CW = $clog2(DEPTH + TAIL + 2);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [3:0]    c_depth = 4'(DEPTH);
  localparam logic [CW-1:0] c_tail  = CW'(TAIL);

  typedef enum logic [0:0] {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t        r_state;
  logic [23:0]   r_buf [DEPTH];
  logic [3:0]    r_count;
  logic [3:0]    r_len;
  logic [CW-1:0] r_c;
  // Skew pipeline: r_v0 holds the vector for lane0 this cycle, r_v1 keeps
  // lanes 1-2 of the previous vector, r_v2 keeps lane 2 from two cycles ago.
  logic [23:0]   r_v0;
  logic [15:0]   r_v1;
  logic [7:0]    r_v2;
  logic          r_en;
  logic          r_done;

  logic          w_accept;
  logic [3:0]    w_eff_cnt;
  logic [23:0]   w_first_vec;
  logic [CW-1:0] w_next_c;
  logic [CW-1:0] w_end_c;
  logic [AW-1:0] w_rd_idx;
  logic [23:0]   w_run_vec;

  assign vec_ready = (r_state == S_LOAD) && !rst && (r_count < c_depth);
  assign w_accept  = vec_valid && vec_ready;
  assign w_eff_cnt = r_count + {3'b000, w_accept};

  // A vector accepted in the start cycle into an empty buffer is not yet in
  // storage, so lane0 for c=0 is taken straight from the input.
  assign w_first_vec = (r_count == 4'd0) ? vec_i : r_buf[0];

  assign w_next_c  = r_c + 1'b1;
  assign w_end_c   = CW'(r_len) + c_tail - 1'b1;
  assign w_rd_idx  = w_next_c[AW-1:0];
  assign w_run_vec = (w_next_c < CW'(r_len)) ? r_buf[w_rd_idx] : 24'd0;

  assign act_o   = {r_v2, r_v1[7:0], r_v0[7:0]};
  assign en_o    = r_en;
  assign busy    = (r_state == S_RUN);
  assign done    = r_done;
  assign count_o = r_count;

  // Vector storage: written only on acceptance, which cannot happen in RUN.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_count[AW-1:0]] <= vec_i;
    end
  end

  // Control FSM with registered skew pipeline, enable and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_LOAD;
      r_count <= 4'd0;
      r_len   <= 4'd0;
      r_c     <= '0;
      r_v0    <= 24'd0;
      r_v1    <= 16'd0;
      r_v2    <= 8'd0;
      r_en    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_LOAD) begin
        if (w_accept) begin
          r_count <= r_count + 4'd1;
        end
        if (start && (w_eff_cnt != 4'd0)) begin
          r_state <= S_RUN;
          r_len   <= w_eff_cnt;
          r_c     <= '0;
          r_en    <= 1'b1;
          r_v0    <= w_first_vec;
          r_v1    <= 16'd0;
          r_v2    <= 8'd0;
        end
      end else begin
        if (r_c == w_end_c) begin
          r_state <= S_LOAD;
          r_count <= 4'd0;
          r_en    <= 1'b0;
          r_done  <= 1'b1;
          r_v0    <= 24'd0;
          r_v1    <= 16'd0;
          r_v2    <= 8'd0;
        end else begin
          r_c  <= w_next_c;
          r_v0 <= w_run_vec;
          r_v1 <= r_v0[23:8];
          r_v2 <= r_v1[15:8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tpu_act_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_tpu_act_feeder
// Description : Scoreboard bench for tpu_act_feeder. A bench-side buffer model
//               builds the expected skewed stream when start is driven; the
//               stream is popped and compared while the DUT runs.
// Revision    : 1.0  initial release
// ============================================================================
module tb_tpu_act_feeder;

  localparam int DEPTH = 8;
  localparam int TAIL  = 4;

  logic        clk;
  logic        rst;
  logic [23:0] vec_i;
  logic        vec_valid;
  logic        vec_ready;
  logic        start;
  logic [23:0] act_o;
  logic        en_o;
  logic        busy;
  logic        done;
  logic [3:0]  count_o;

  int n_checks;
  int n_fail;

  logic [23:0] m_buf[$];
  logic [23:0] m_exp[$];

  tpu_act_feeder #(.DEPTH(DEPTH), .TAIL(TAIL)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .vec_i     (vec_i),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .start     (start),
    .act_o     (act_o),
    .en_o      (en_o),
    .busy      (busy),
    .done      (done),
    .count_o   (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Expected act_o in run cycle c, from the bench's own copy of the buffer.
  function automatic logic [23:0] model_act(input int c);
    logic [23:0] r;
    logic [23:0] v;
    r = 24'd0;
    for (int k = 0; k < 3; k++) begin
      if ((c - k) >= 0 && (c - k) < m_buf.size()) begin
        v = m_buf[c - k];
        r[8*k +: 8] = v[8*k +: 8];
      end
    end
    return r;
  endfunction

  task automatic load(input logic [23:0] v);
    vec_i     = v;
    vec_valid = 1'b1;
    check("ready_load", {31'd0, vec_ready}, {31'd0, (m_buf.size() < DEPTH)});
    if (m_buf.size() < DEPTH) m_buf.push_back(v);
    @(negedge clk);
    vec_valid = 1'b0;
  endtask

  // Drive start, then compare every RUN cycle against the scoreboard.
  task automatic do_run(input bit junk);
    int len;
    len = m_buf.size();
    for (int c = 0; c < len + TAIL; c++) m_exp.push_back(model_act(c));
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    vec_valid = 1'b0;
    while (m_exp.size() > 0) begin
      check("run_en",    {31'd0, en_o},      32'd1);
      check("run_busy",  {31'd0, busy},      32'd1);
      check("run_ready", {31'd0, vec_ready}, 32'd0);
      check("run_done",  {31'd0, done},      32'd0);
      check("run_cnt",   {28'd0, count_o},   32'(len));
      check("run_act",   {8'd0, act_o},      {8'd0, m_exp.pop_front()});
      if (junk) begin
        start     = 1'b1;
        vec_valid = 1'b1;
        vec_i     = 24'($urandom);
      end
      @(negedge clk);
    end
    start     = 1'b0;
    vec_valid = 1'b0;
    check("end_done", {31'd0, done},    32'd1);
    check("end_en",   {31'd0, en_o},    32'd0);
    check("end_busy", {31'd0, busy},    32'd0);
    check("end_act",  {8'd0, act_o},    32'd0);
    check("end_cnt",  {28'd0, count_o}, 32'd0);
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd0);
    m_buf.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    vec_i     = 24'd0;
    vec_valid = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    // Reset state, with inputs active to prove they are masked.
    check("rst_ready", {31'd0, vec_ready}, 32'd0);
    check("rst_cnt",   {28'd0, count_o},   32'd0);
    check("rst_en",    {31'd0, en_o},      32'd0);
    check("rst_busy",  {31'd0, busy},      32'd0);
    check("rst_done",  {31'd0, done},      32'd0);
    check("rst_act",   {8'd0, act_o},      32'd0);
    vec_valid = 1'b0;
    start     = 1'b0;
    rst       = 1'b0;
    @(negedge clk);

    // Start with an empty buffer is ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("empty_busy", {31'd0, busy}, 32'd0);
      check("empty_en",   {31'd0, en_o}, 32'd0);
      check("empty_done", {31'd0, done}, 32'd0);
      check("empty_rdy",  {31'd0, vec_ready}, 32'd1);
      @(negedge clk);
    end

    // Two-vector reference stream.
    load(24'h030201);
    load(24'h060504);
    check("cnt2", {28'd0, count_o}, 32'd2);
    do_run(1'b0);

    // Overfill: nine offered, eight stored.
    for (int i = 0; i < 9; i++) load(24'h100000 + 24'(i * 24'h010203));
    check("cnt_full", {28'd0, count_o}, 32'd8);
    check("rdy_full", {31'd0, vec_ready}, 32'd0);
    do_run(1'b0);

    // Vector accepted in the same cycle as start with an empty buffer.
    vec_i     = 24'h0A0B0C;
    vec_valid = 1'b1;
    m_buf.push_back(24'h0A0B0C);
    do_run(1'b0);

    // Start and vec_valid asserted throughout RUN have no effect.
    load(24'h112233);
    load(24'h445566);
    load(24'h778899);
    do_run(1'b1);

    // Reset during c=2 of a four-vector run aborts immediately.
    for (int i = 0; i < 4; i++) load(24'($urandom));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ab_c0", {8'd0, act_o}, {8'd0, model_act(0)});
    @(negedge clk);
    check("ab_c1", {8'd0, act_o}, {8'd0, model_act(1)});
    @(posedge clk);
    #1;
    check("ab_c2", {8'd0, act_o}, {8'd0, model_act(2)});
    rst = 1'b1;
    #1;
    check("ab_act",  {8'd0, act_o},    32'd0);
    check("ab_en",   {31'd0, en_o},    32'd0);
    check("ab_busy", {31'd0, busy},    32'd0);
    check("ab_cnt",  {28'd0, count_o}, 32'd0);
    check("ab_rdy",  {31'd0, vec_ready}, 32'd0);
    m_buf.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("ab_nodone", {31'd0, done}, 32'd0);
      @(negedge clk);
    end
    load(24'hA1B2C3);
    load(24'hD4E5F6);
    do_run(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tpu_act_feeder.md
TPU_ACT_FEEDER -- requirements
Module: tpu_act_feeder

Interface
REQ-001 Parameter DEPTH, default 8: vector buffer capacity, in vectors.
REQ-002 Parameter TAIL, default 4: zero-padded cycles appended after the last vector; covers the 2-cycle lane skew plus 2 cycles of horizontal propagation.
REQ-003 clk  in  1: single clock; all state updates on the rising edge.
REQ-004 rst  in  1: asynchronous, active-high reset.
REQ-005 vec_i  in  24: activation vector; lane0=[7:0], lane1=[15:8], lane2=[23:16], 8-bit unsigned each.
REQ-006 vec_valid  in  1: vec_i is valid this cycle.
REQ-007 vec_ready  out  1: the block accepts vec_i this cycle.
REQ-008 start  in  1: single-cycle request to stream all buffered vectors.
REQ-009 act_o  out  24: skewed activations to the 3x3 array left inputs; lane0->row1, lane1->row2, lane2->row3.
REQ-010 en_o  out  1: array enable; high throughout streaming.
REQ-011 busy  out  1: high while in RUN.
REQ-012 done  out  1: one-cycle pulse when streaming completes.
REQ-013 count_o  out  4: number of vectors currently buffered.

Function
REQ-014 FSM has two states: LOAD and RUN; the reset state is LOAD.
REQ-015 In LOAD, vec_ready is combinational and equals (count_o < DEPTH); in RUN, vec_ready is 0.
REQ-016 On vec_valid && vec_ready, vec_i is written at buffer index count_o and count_o increments by 1 on that edge.
REQ-017 When count_o == DEPTH, vec_ready is 0, vec_valid is ignored, and nothing is overwritten.
REQ-018 In LOAD, start with an effective count of 0 is ignored: no state change, no en_o, no done.
REQ-019 Effective count is count_o plus 1 if a vector is accepted in the same cycle as start.
REQ-020 In LOAD, start with an effective count > 0 moves the FSM to RUN on that edge and latches the effective count as L.
REQ-021 Let c be the RUN cycle index, with c=0 being the first cycle in RUN.
REQ-022 Lane r of act_o (r=0..2), registered, is V[c-r][r] when 0 <= c-r < L, else 0.
REQ-023 en_o is 1 for exactly L+TAIL consecutive cycles, c=0..L+TAIL-1, and 0 otherwise.
REQ-024 busy equals the RUN state.
REQ-025 After cycle c=L+TAIL-1, the FSM returns to LOAD, count_o becomes 0, and done is 1 for the first LOAD cycle only.
REQ-026 start, vec_valid and vec_i are ignored in RUN; buffer contents are not modified during RUN.
REQ-027 act_o is 0 whenever en_o is 0.
REQ-028 Lane values pass through unmodified: no arithmetic or saturation on data.

Reset
REQ-029 While rst is high: state=LOAD, count_o=0, act_o=0, en_o=0, busy=0, done=0, skew registers=0; vec_ready is 0 while rst is asserted.
REQ-030 rst asserted mid-RUN aborts immediately: no done pulse, and buffered vectors are discarded (count_o=0).
REQ-031 Buffer storage needs no reset; it is never read beyond index L-1.

Verification
REQ-032 Load V0=0x030201, V1=0x060504, start -> act_o per cycle c=0..5: 0x000001, 0x000204, 0x030500, 0x060000, 0x000000, 0x000000; en_o high for 6 cycles; done pulses at c=6.
REQ-033 Hold vec_valid high with 9 distinct vectors -> vec_ready drops after the 8th acceptance, count_o=8, the 9th vector is not stored; streaming outputs only the first 8.
REQ-034 start with count_o=0 -> en_o, busy and done stay 0 and the FSM remains in LOAD.
REQ-035 vec_valid (vec_i=0x0A0B0C) and start in the same cycle with count_o=0 -> L=1; lane0=0x0C at c=0, lane1=0x0B at c=1, lane2=0x0A at c=2; en_o high for 5 cycles.
REQ-036 Assert rst at c=2 of a 4-vector run -> act_o=0, en_o=0, busy=0 and count_o=0 immediately; no done pulse; a new load/start after reset streams correctly.
REQ-037 Assert start and vec_valid during RUN -> no effect on act_o or count_o, and vec_ready stays 0.
